// File: rtl/serial_rx_ctrl.sv
// LSB-first serial-to-parallel receiver: frames on start, counts WIDTH qualified bits,
// queues completed words in a 2-entry valid/ready buffer with overrun and frame accounting.
module serial_rx_ctrl #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic             i_din,
  input  logic             i_din_vld,
  input  logic             i_out_ready,
  input  logic             i_ovr_clr,
  output logic [WIDTH-1:0] o_out_data,
  output logic             o_out_valid,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_overrun,
  output logic [7:0]       o_frame_cnt
);

  typedef enum logic {ST_IDLE = 1'b0, ST_SHIFT = 1'b1} state_t;

  state_t           r_state;
  state_t           w_next_state;
  logic [WIDTH-1:0] r_sr;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_buf0;
  logic [WIDTH-1:0] r_buf1;
  logic [1:0]       r_count;
  logic             r_done;
  logic             r_overrun;
  logic [7:0]       r_frame_cnt;

  logic             w_clear;
  logic             w_shift;
  logic             w_complete;
  logic             w_pop;
  logic             w_push;
  logic             w_drop;
  logic [WIDTH-1:0] w_word;

  assign w_word = {i_din, r_sr[WIDTH-1:1]};

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // start always wins over din_vld, including on the would-be final bit
  always_comb begin
    w_next_state = r_state;
    w_clear      = 1'b0;
    w_shift      = 1'b0;
    w_complete   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (i_start) begin
          w_clear      = 1'b1;
          w_next_state = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (i_start) begin
          w_clear = 1'b1;
        end else if (i_din_vld) begin
          if (r_cnt == CNT_W'(WIDTH - 1)) begin
            w_complete   = 1'b1;
            w_next_state = ST_IDLE;
          end else begin
            w_shift = 1'b1;
          end
        end
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  // A full buffer still accepts a completing word if the head is popped this cycle
  assign w_pop  = (r_count != 2'd0) && i_out_ready;
  assign w_push = w_complete && ((r_count != 2'd2) || w_pop);
  assign w_drop = w_complete && !w_push;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sr  <= '0;
      r_cnt <= '0;
    end else if (w_clear) begin
      r_sr  <= '0;
      r_cnt <= '0;
    end else if (w_shift) begin
      r_sr  <= w_word;
      r_cnt <= r_cnt + 1'b1;
    end else if (w_complete) begin
      r_cnt <= '0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_buf0  <= '0;
      r_buf1  <= '0;
      r_count <= 2'd0;
    end else begin
      case ({w_push, w_pop})
        2'b11: begin
          if (r_count == 2'd1) begin
            r_buf0 <= w_word;
          end else begin
            r_buf0 <= r_buf1;
            r_buf1 <= w_word;
          end
        end
        2'b10: begin
          if (r_count == 2'd0) begin
            r_buf0 <= w_word;
          end else begin
            r_buf1 <= w_word;
          end
          r_count <= r_count + 2'd1;
        end
        2'b01: begin
          r_buf0  <= r_buf1;
          r_count <= r_count - 2'd1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_done      <= 1'b0;
      r_overrun   <= 1'b0;
      r_frame_cnt <= 8'd0;
    end else begin
      r_done <= w_complete;
      if (w_drop) begin
        r_overrun <= 1'b1;
      end else if (i_ovr_clr) begin
        r_overrun <= 1'b0;
      end
      if (w_push) begin
        r_frame_cnt <= r_frame_cnt + 8'd1;
      end
    end
  end

  assign o_out_data  = r_buf0;
  assign o_out_valid = (r_count != 2'd0);
  assign o_busy      = (r_state == ST_SHIFT);
  assign o_done      = r_done;
  assign o_overrun   = r_overrun;
  assign o_frame_cnt = r_frame_cnt;

endmodule
